// File: rtl/cache_mem_arbiter.sv
// Memory-port arbiter shared by the I-cache refill path and the D-cache refill/writeback path.
// Each grant runs one incrementing cache-line burst of BURST_LEN word beats, followed by a one-cycle gap.
module cache_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_gnt_o,
  output logic              ic_rvalid_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic              dc_rvalid_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_wready_o,
  output logic              dc_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BASE_W = ADDR_W - BEAT_W - 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IC_RD = 3'd1;
  localparam logic [2:0] S_DC_RD = 3'd2;
  localparam logic [2:0] S_DC_WR = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic              last_owner;
  logic              last_owner_nxt;
  logic [BASE_W-1:0] line_base;

  logic grant_ic;
  logic grant_dc;
  logic burst;
  logic last_beat;
  logic beat_done;

  // Byte offset inside the line is irrelevant: bursts always start at beat 0.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr_i[BEAT_W+1:0], dc_addr_i[BEAT_W+1:0]};

  // Round-robin on a tie: the requester that did not own the port last time wins.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (ic_req_i && dc_req_i) begin
      if (last_owner == OWNER_IC) grant_dc = 1'b1;
      else                        grant_ic = 1'b1;
    end else begin
      grant_ic = ic_req_i;
      grant_dc = dc_req_i;
    end
  end

  assign burst     = (state == S_IC_RD) || (state == S_DC_RD) || (state == S_DC_WR);
  assign last_beat = (beat == BEAT_LAST);
  assign beat_done = burst && mem_ack_i;

  always_comb begin
    state_nxt      = state;
    beat_nxt       = beat;
    last_owner_nxt = last_owner;
    case (state)
      S_IDLE: begin
        if (grant_dc) begin
          state_nxt      = dc_we_i ? S_DC_WR : S_DC_RD;
          beat_nxt       = '0;
          last_owner_nxt = OWNER_DC;
        end else if (grant_ic) begin
          state_nxt      = S_IC_RD;
          beat_nxt       = '0;
          last_owner_nxt = OWNER_IC;
        end
      end
      S_IC_RD, S_DC_RD, S_DC_WR: begin
        if (mem_ack_i) begin
          beat_nxt = beat + BEAT_ONE;
          if (last_beat) state_nxt = S_GAP;
        end
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      beat       <= '0;
      last_owner <= OWNER_IC;
    end else begin
      state      <= state_nxt;
      beat       <= beat_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Line base is pure data and only consumed while a burst state holds it valid.
  always_ff @(posedge clk_i) begin
    if ((state == S_IDLE) && (grant_ic || grant_dc)) begin
      line_base <= grant_dc ? dc_addr_i[ADDR_W-1:BEAT_W+2] : ic_addr_i[ADDR_W-1:BEAT_W+2];
    end
  end

  assign ic_gnt_o    = (state == S_IC_RD);
  assign dc_gnt_o    = (state == S_DC_RD) || (state == S_DC_WR);

  assign mem_req_o   = burst;
  assign mem_we_o    = (state == S_DC_WR);
  assign mem_addr_o  = burst ? {line_base, beat, 2'b00} : '0;
  assign mem_wdata_o = mem_we_o ? dc_wdata_i : '0;

  assign ic_rvalid_o = (state == S_IC_RD) && mem_ack_i;
  assign ic_rdata_o  = ic_rvalid_o ? mem_rdata_i : '0;
  assign ic_done_o   = ic_gnt_o && beat_done && last_beat;

  assign dc_rvalid_o = (state == S_DC_RD) && mem_ack_i;
  assign dc_rdata_o  = dc_rvalid_o ? mem_rdata_i : '0;
  assign dc_wready_o = (state == S_DC_WR) && mem_ack_i;
  assign dc_done_o   = dc_gnt_o && beat_done && last_beat;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed address/grant-order expectations.
module tb_cache_mem_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int OWN_NONE  = 0;
  localparam int OWN_IC    = 1;
  localparam int OWN_DC    = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              ic_req_i = 1'b0;
  logic [ADDR_W-1:0] ic_addr_i = '0;
  logic              ic_gnt_o;
  logic              ic_rvalid_o;
  logic [DATA_W-1:0] ic_rdata_o;
  logic              ic_done_o;
  logic              dc_req_i = 1'b0;
  logic              dc_we_i = 1'b0;
  logic [ADDR_W-1:0] dc_addr_i = '0;
  logic [DATA_W-1:0] dc_wdata_i = '0;
  logic              dc_gnt_o;
  logic              dc_rvalid_o;
  logic [DATA_W-1:0] dc_rdata_o;
  logic              dc_wready_o;
  logic              dc_done_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o),
    .dc_wready_o(dc_wready_o), .dc_done_o(dc_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  initial forever #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, which beat, and whether the post-burst gap is pending.
  int          m_owner = OWN_NONE;
  bit          m_write = 1'b0;
  int          m_beat  = 0;
  logic [31:0] m_base  = '0;
  bit          m_gap   = 1'b0;
  int          m_last  = OWN_IC;
  int          m_win;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_owner = OWN_NONE; m_write = 1'b0; m_beat = 0; m_gap = 1'b0; m_last = OWN_IC;
    end else if (m_owner != OWN_NONE) begin
      if (mem_ack_i) begin
        if (m_beat == BURST_LEN - 1) begin
          m_owner = OWN_NONE; m_gap = 1'b1; m_beat = 0;
        end else begin
          m_beat = m_beat + 1;
        end
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (ic_req_i || dc_req_i) begin
      if (ic_req_i && dc_req_i) m_win = (m_last == OWN_IC) ? OWN_DC : OWN_IC;
      else                      m_win = ic_req_i ? OWN_IC : OWN_DC;
      m_owner = m_win;
      m_last  = m_win;
      m_beat  = 0;
      m_write = (m_win == OWN_DC) && dc_we_i;
      m_base  = ((m_win == OWN_DC) ? dc_addr_i : ic_addr_i) & ~32'(BURST_LEN * 4 - 1);
    end
  end

  // Per-cycle compare plus logs the directed tests inspect.
  logic [31:0] ic_addr_log[$];
  logic [31:0] dc_wr_log[$];
  int          grant_log[$];
  int          dc_gnt_cycles = 0;
  logic        prev_ic_gnt = 1'b0;
  logic        prev_dc_gnt = 1'b0;
  bit          e_ic, e_dc, e_rd, e_wr, e_last;

  always @(negedge clk_i) begin
    e_ic   = (m_owner == OWN_IC);
    e_dc   = (m_owner == OWN_DC);
    e_rd   = e_dc && !m_write;
    e_wr   = e_dc && m_write;
    e_last = (m_beat == BURST_LEN - 1);
    check("ic_gnt",      ic_gnt_o,    e_ic);
    check("dc_gnt",      dc_gnt_o,    e_dc);
    check("mem_req",     mem_req_o,   e_ic || e_dc);
    check("mem_we",      mem_we_o,    e_wr);
    check("mem_addr",    mem_addr_o,  (e_ic || e_dc) ? m_base + 32'(4 * m_beat) : 32'h0);
    check("mem_wdata",   mem_wdata_o, e_wr ? dc_wdata_i : 32'h0);
    check("ic_rvalid",   ic_rvalid_o, e_ic && mem_ack_i);
    check("ic_rdata",    ic_rdata_o,  (e_ic && mem_ack_i) ? mem_rdata_i : 32'h0);
    check("ic_done",     ic_done_o,   e_ic && mem_ack_i && e_last);
    check("dc_rvalid",   dc_rvalid_o, e_rd && mem_ack_i);
    check("dc_rdata",    dc_rdata_o,  (e_rd && mem_ack_i) ? mem_rdata_i : 32'h0);
    check("dc_wready",   dc_wready_o, e_wr && mem_ack_i);
    check("dc_done",     dc_done_o,   e_dc && mem_ack_i && e_last);
    if (ic_rvalid_o) ic_addr_log.push_back(mem_addr_o);
    if (dc_wready_o) dc_wr_log.push_back(mem_addr_o);
    if (dc_gnt_o) dc_gnt_cycles++;
    if (ic_gnt_o && !prev_ic_gnt) grant_log.push_back(OWN_IC);
    if (dc_gnt_o && !prev_dc_gnt) grant_log.push_back(OWN_DC);
    prev_ic_gnt = ic_gnt_o;
    prev_dc_gnt = dc_gnt_o;
  end

  // Memory responder: 0 = ack every beat, 1 = ack alternate cycles, 2 = stall stall_cnt cycles first.
  int ack_mode  = 0;
  int stall_cnt = 0;
  bit phase     = 1'b0;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (!mem_req_o) begin
        mem_ack_i = 1'b0;
        phase     = 1'b0;
      end else begin
        case (ack_mode)
          1: begin mem_ack_i = phase; phase = ~phase; end
          2: begin
            if (stall_cnt > 0) begin mem_ack_i = 1'b0; stall_cnt--; end
            else mem_ack_i = 1'b1;
          end
          default: mem_ack_i = 1'b1;
        endcase
      end
      mem_rdata_i = mem_ack_i ? (32'hA5A5_0000 ^ mem_addr_o) : 32'h0BAD_BEEF;
      dc_wdata_i  = 32'hD000_0000 ^ mem_addr_o;
    end
  end

  function automatic bit sig_sel(input int which);
    case (which)
      0:       return ic_done_o;
      1:       return dc_done_o;
      2:       return ic_done_o || dc_done_o;
      3:       return ic_gnt_o;
      4:       return dc_gnt_o;
      5:       return ic_gnt_o || dc_gnt_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Returns at the first falling edge where the selected signal is high, or reports a timeout.
  task automatic wait_sig(input int which, input int bound, input string name);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!sig_sel(which) && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    if (!sig_sel(which)) begin
      tests++;
      fails++;
      $display("FAIL %s timeout after %0d cycles", name, bound);
    end
  endtask

  initial begin
    int n;
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) tick();
    rst_i = 1'b0;
    check("rst_ic_gnt",   ic_gnt_o,   1'b0);
    check("rst_dc_gnt",   dc_gnt_o,   1'b0);
    check("rst_mem_req",  mem_req_o,  1'b0);
    check("rst_mem_addr", mem_addr_o, 32'h0);

    // I-cache refill, ack every cycle
    ack_mode  = 0;
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_1008;
    @(negedge clk_i);
    check("t1_lat_before", ic_gnt_o, 1'b0);
    @(negedge clk_i);
    check("t1_lat_after",  ic_gnt_o, 1'b1);
    check("t1_beat0_addr", mem_addr_o, 32'h0000_1000);
    wait_sig(0, 20, "t1_ic_done");
    tick();
    ic_req_i = 1'b0;
    check("t1_gap_gnt",  ic_gnt_o,  1'b0);
    check("t1_gap_req",  mem_req_o, 1'b0);
    check("t1_beats", ic_addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ic_addr_log.size()) check("t1_addr_seq", ic_addr_log[i], 32'h0000_1000 + 32'(4 * i));
    repeat (2) tick();

    // D-cache writeback, ack on alternate cycles
    ack_mode      = 1;
    dc_gnt_cycles = 0;
    dc_wr_log.delete();
    dc_req_i  = 1'b1;
    dc_we_i   = 1'b1;
    dc_addr_i = 32'h0000_2010;
    wait_sig(1, 40, "t2_dc_done");
    tick();
    dc_req_i = 1'b0;
    check("t2_wr_beats",   dc_wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < dc_wr_log.size()) check("t2_addr_seq", dc_wr_log[i], 32'h0000_2010 + 32'(4 * i));
    check("t2_gnt_cycles", dc_gnt_cycles, 8);
    ack_mode = 0;
    repeat (2) tick();

    // Simultaneous requests after reset: D first, then alternating
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    grant_log.delete();
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_3004;
    dc_req_i  = 1'b1;
    dc_we_i   = 1'b0;
    dc_addr_i = 32'h0000_4000;
    for (int k = 0; k < 3; k++) wait_sig(2, 20, "t3_done");
    tick();
    ic_req_i = 1'b0;
    dc_req_i = 1'b0;
    check("t3_grants", grant_log.size(), 3);
    if (grant_log.size() > 0) check("t3_grant0", grant_log[0], OWN_DC);
    if (grant_log.size() > 1) check("t3_grant1", grant_log[1], OWN_IC);
    if (grant_log.size() > 2) check("t3_grant2", grant_log[2], OWN_DC);
    repeat (2) tick();

    // D-cache request arrives mid I-cache burst: no preemption
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_5000;
    wait_sig(3, 10, "t4_ic_gnt");
    tick();
    dc_req_i  = 1'b1;
    dc_we_i   = 1'b0;
    dc_addr_i = 32'h0000_6000;
    wait_sig(0, 10, "t4_ic_done");
    tick();
    ic_req_i = 1'b0;
    n = 1;
    @(negedge clk_i);
    while (!dc_gnt_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    check("t4_dc_gnt_delay", n, 3);
    check("t4_dc_addr", mem_addr_o, 32'h0000_6000);
    wait_sig(1, 10, "t4_dc_done");
    tick();
    dc_req_i = 1'b0;
    repeat (2) tick();

    // Asynchronous reset at beat 2
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_7000;
    wait_sig(3, 10, "t5_ic_gnt");
    @(negedge clk_i);
    @(negedge clk_i);
    check("t5_beat2_addr", mem_addr_o, 32'h0000_7008);
    #2;
    rst_i    = 1'b1;
    ic_req_i = 1'b0;
    #1;
    check("t5_async_gnt",    ic_gnt_o,    1'b0);
    check("t5_async_req",    mem_req_o,   1'b0);
    check("t5_async_addr",   mem_addr_o,  32'h0);
    check("t5_async_rvalid", ic_rvalid_o, 1'b0);
    check("t5_async_rdata",  ic_rdata_o,  32'h0);
    tick();
    rst_i     = 1'b0;
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_8000;
    dc_req_i  = 1'b1;
    dc_we_i   = 1'b1;
    dc_addr_i = 32'h0000_9000;
    wait_sig(5, 10, "t5_regrant");
    check("t5_tie_dc", dc_gnt_o,   1'b1);
    check("t5_tie_ic", ic_gnt_o,   1'b0);
    check("t5_beat0",  mem_addr_o, 32'h0000_9000);
    check("t5_we",     mem_we_o,   1'b1);
    tick();
    ic_req_i = 1'b0;
    wait_sig(1, 10, "t5_dc_done");
    tick();
    dc_req_i = 1'b0;
    repeat (2) tick();

    // Memory stalls 20 cycles on beat 0
    ack_mode  = 2;
    stall_cnt = 20;
    ic_req_i  = 1'b1;
    ic_addr_i = 32'h0000_A00C;
    wait_sig(3, 10, "t6_ic_gnt");
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk_i);
      check("t6_stall_req",    mem_req_o,   1'b1);
      check("t6_stall_addr",   mem_addr_o,  32'h0000_A000);
      check("t6_stall_rvalid", ic_rvalid_o, 1'b0);
    end
    @(negedge clk_i);
    check("t6_first_rvalid", ic_rvalid_o, 1'b1);
    check("t6_first_rdata",  ic_rdata_o,  32'hA5A5_A000);
    wait_sig(0, 10, "t6_ic_done");
    tick();
    ic_req_i = 1'b0;
    ack_mode = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
